pow_sqmul: RTL and testbench

Parametrised fixed-point power unit computing a^b for signed integer base and signed integer exponent. Returns a signed Q(M-F).F result using square-and-multiply, so latency scales with the exponent's bit length rather than its value. Supports negative bases and, when compiled in, negative exponents via a reciprocal divider. Sits in the calculator execute stage beside the other arithmetic units and is driven by the control FSM through a start/done handshake.

---
 rtl/pow_sqmul_pkg.sv | 26 ++
 rtl/pow_sqmul_if.sv | 29 ++
 rtl/fx_recip_div.sv | 71 +++++++
 rtl/pow_sqmul.sv | 203 ++++++++++++++++++++
 tb/tb_pow_sqmul.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/pow_sqmul_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pow_sqmul_pkg
// Brief   : FSM state encodings, default error value and the integer-limit
//           helper shared by the pow_sqmul power unit.
// Revision: 1.0
// ============================================================================
package pow_sqmul_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_LOOP  = 3'd2,
        S_RECIP = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [31:0] C_ERR_VAL = 32'hDEADBEEF;

    // Largest integer magnitude representable in signed Q(M-F).F.
    function automatic logic [127:0] pow_lim(input int m, input int f);
        return (128'd1 << (m - f - 1)) - 128'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pow_sqmul_if.sv
`default_nettype none
// ============================================================================
// Module  : pow_sqmul_if
// Brief   : start/done request bus between the control FSM and pow_sqmul.
// Revision: 1.0
// ============================================================================
interface pow_sqmul_if #(
    parameter int N = 16,
    parameter int M = 32
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic         error;
    logic [M-1:0] o_pow;

    modport master (
        output start, a, b,
        input  busy, done, error, o_pow
    );

    modport slave (
        input  start, a, b,
        output busy, done, error, o_pow
    );
endinterface
`default_nettype wire

// File: rtl/fx_recip_div.sv
`default_nettype none
// ============================================================================
// Module  : fx_recip_div
// Brief   : Restoring unsigned divider, one quotient bit per cycle, M cycles.
// Revision: 1.0
// ============================================================================
module fx_recip_div #(
    parameter int M = 32
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         start,
    input  wire logic [M-1:0] num,
    input  wire logic [M-1:0] den,
    output logic              done,
    output logic [M-1:0]      quot
);
    localparam int C_CW = $clog2(M + 1);

    logic [M-1:0]    r_rem;
    logic [M-1:0]    r_quo;
    logic [M-1:0]    r_den;
    logic [C_CW-1:0] r_cnt;
    logic            r_run;
    logic            r_done;

    logic [M:0]      w_rem_sh;
    logic [M:0]      w_diff;

    // Remainder stays below den, so M+1 bits hold the shifted trial value.
    assign w_rem_sh = {r_rem, r_quo[M-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_den};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_den  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_rem <= '0;
                r_quo <= num;
                r_den <= den;
                r_cnt <= C_CW'(M);
                r_run <= 1'b1;
            end else if (r_run) begin
                if (w_diff[M]) begin
                    r_rem <= w_rem_sh[M-1:0];
                    r_quo <= {r_quo[M-2:0], 1'b0};
                end else begin
                    r_rem <= w_diff[M-1:0];
                    r_quo <= {r_quo[M-2:0], 1'b1};
                end
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == C_CW'(1)) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done = r_done;
    assign quot = r_quo;

endmodule
`default_nettype wire

// File: rtl/pow_sqmul.sv
`default_nettype none
// ============================================================================
// Module  : pow_sqmul
// Brief   : Square-and-multiply a^b, signed integer inputs, signed Q(M-F).F
//           result. Define POW_NEG_EXP_EN to enable negative exponents.
// Revision: 1.0
// ============================================================================
module pow_sqmul
    import pow_sqmul_pkg::*;
#(
    parameter int           N       = 16,
    parameter int           M       = 32,
    parameter int           F       = 8,
    parameter logic [M-1:0] ERR_VAL = M'(C_ERR_VAL)
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    pow_sqmul_if.slave bus
);
    localparam logic [M-1:0]   C_ONE = {{(M-1){1'b0}}, 1'b1} << F;
    localparam logic [2*M-1:0] C_LIM = (2*M)'(pow_lim(M, F));

    state_t         r_state, w_state_nxt;
    logic [N-1:0]   r_a, w_a_nxt;
    logic [N-1:0]   r_b, w_b_nxt;
    logic [N-1:0]   r_e, w_e_nxt;
    logic [M-1:0]   r_acc, w_acc_nxt;
    logic [M-1:0]   r_sq, w_sq_nxt;
    logic           r_sq_ovf, w_sq_ovf_nxt;
    logic           r_neg, w_neg_nxt;
    logic           r_busy, w_busy_nxt;
    logic           r_done, w_done_nxt;
    logic           r_error, w_error_nxt;
    logic [M-1:0]   r_pow, w_pow_nxt;

    logic [N-1:0]   w_abs_a;
    logic [N-1:0]   w_abs_b;
    logic [2*M-1:0] w_prod_acc;
    logic [2*M-1:0] w_prod_sq;
    logic [N-1:0]   w_e_shr;
    logic [M-1:0]   w_pos_res;
    logic           w_err_hit;

    assign w_abs_a    = r_a[N-1] ? (~r_a + 1'b1) : r_a;
    assign w_abs_b    = r_b[N-1] ? (~r_b + 1'b1) : r_b;
    assign w_prod_acc = {{M{1'b0}}, r_acc} * {{M{1'b0}}, r_sq};
    assign w_prod_sq  = {{M{1'b0}}, r_sq} * {{M{1'b0}}, r_sq};
    assign w_e_shr    = r_e >> 1;

`ifdef POW_NEG_EXP_EN
    logic         w_div_start;
    logic         w_div_done;
    logic [M-1:0] w_div_quot;

    fx_recip_div #(.M(M)) u_recip_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_div_start),
        .num   (C_ONE),
        .den   (w_acc_nxt),
        .done  (w_div_done),
        .quot  (w_div_quot)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_e_nxt      = r_e;
        w_acc_nxt    = r_acc;
        w_sq_nxt     = r_sq;
        w_sq_ovf_nxt = r_sq_ovf;
        w_neg_nxt    = r_neg;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_error_nxt  = r_error;
        w_pow_nxt    = r_pow;
        w_err_hit    = 1'b0;
        w_pos_res    = '0;
`ifdef POW_NEG_EXP_EN
        w_div_start  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_a_nxt     = bus.a;
                    w_b_nxt     = bus.b;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                w_state_nxt = S_DONE;
                if (r_b == '0) begin
                    w_pow_nxt   = C_ONE;
                    w_error_nxt = 1'b0;
                end else if (r_a == '0) begin
                    w_pow_nxt   = r_b[N-1] ? ERR_VAL : '0;
                    w_error_nxt = r_b[N-1];
`ifndef POW_NEG_EXP_EN
                end else if (r_b[N-1]) begin
                    w_pow_nxt   = ERR_VAL;
                    w_error_nxt = 1'b1;
`endif
                end else begin
                    w_acc_nxt    = {{(M-1){1'b0}}, 1'b1};
                    w_sq_nxt     = M'(w_abs_a);
                    w_sq_ovf_nxt = {{M{1'b0}}, M'(w_abs_a)} > C_LIM;
                    w_e_nxt      = w_abs_b;
                    w_neg_nxt    = r_a[N-1] & r_b[0];
                    w_state_nxt  = S_LOOP;
                end
            end
            S_LOOP: begin
                if (r_e[0]) begin
                    if (r_sq_ovf || (w_prod_acc > C_LIM)) w_err_hit = 1'b1;
                    else                                  w_acc_nxt = w_prod_acc[M-1:0];
                end
                // The square is always taken; its overflow only matters once used.
                w_sq_nxt = w_prod_sq[M-1:0];
                if (w_prod_sq > C_LIM) w_sq_ovf_nxt = 1'b1;
                w_e_nxt   = w_e_shr;
                w_pos_res = w_acc_nxt << F;
                if (w_err_hit) begin
                    w_pow_nxt   = ERR_VAL;
                    w_error_nxt = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (w_e_shr == '0) begin
`ifdef POW_NEG_EXP_EN
                    if (r_b[N-1]) begin
                        w_div_start = 1'b1;
                        w_state_nxt = S_RECIP;
                    end else begin
                        w_pow_nxt   = r_neg ? (~w_pos_res + 1'b1) : w_pos_res;
                        w_error_nxt = 1'b0;
                        w_state_nxt = S_DONE;
                    end
`else
                    w_pow_nxt   = r_neg ? (~w_pos_res + 1'b1) : w_pos_res;
                    w_error_nxt = 1'b0;
                    w_state_nxt = S_DONE;
`endif
                end
            end
`ifdef POW_NEG_EXP_EN
            S_RECIP: begin
                if (w_div_done) begin
                    w_pow_nxt   = r_neg ? (~w_div_quot + 1'b1) : w_div_quot;
                    w_error_nxt = 1'b0;
                    w_state_nxt = S_DONE;
                end
            end
`endif
            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_e      <= '0;
            r_acc    <= '0;
            r_sq     <= '0;
            r_sq_ovf <= 1'b0;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_pow    <= '0;
        end else begin
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_e      <= w_e_nxt;
            r_acc    <= w_acc_nxt;
            r_sq     <= w_sq_nxt;
            r_sq_ovf <= w_sq_ovf_nxt;
            r_neg    <= w_neg_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_error  <= w_error_nxt;
            r_pow    <= w_pow_nxt;
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.error = r_error;
    assign bus.o_pow = r_pow;

endmodule
`default_nettype wire

// File: tb/tb_pow_sqmul.sv
`default_nettype none
// ============================================================================
// Module  : tb_pow_sqmul
// Brief   : Scoreboard bench for pow_sqmul (M=32, F=8), directed vectors.
// Revision: 1.0
// ============================================================================
module tb_pow_sqmul;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pow_sqmul_if #(.N(16), .M(32)) bus ();

    pow_sqmul #(.N(16), .M(32), .F(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] pow;
        logic        err;
        int unsigned edge_exp;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_pow"},   bus.o_pow, mon_e.pow);
                chk({mon_e.name, "_err"},   32'(bus.error), 32'(mon_e.err));
                chk({mon_e.name, "_cycle"}, cyc, mon_e.edge_exp);
            end
        end
    end

    // Called just after a negedge; returns at the negedge where busy drops.
    task automatic issue(input string nm, input int av, input int bv,
                         input logic [31:0] pw, input logic er, input int lat,
                         input bit poke);
        exp_t e;
        bit   got;
        bus.a     = 16'(av);
        bus.b     = 16'(bv);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        e.name     = nm;
        e.pow      = pw;
        e.err      = er;
        e.edge_exp = cyc + 32'(lat);
        sb.push_back(e);
        if (poke) begin
            @(negedge clk);
            bus.a     = 16'(7);
            bus.b     = 16'(2);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=busy required=done", nm);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy",  32'(bus.busy),  32'd0);
        chk("reset_done",  32'(bus.done),  32'd0);
        chk("reset_error", 32'(bus.error), 32'd0);
        chk("reset_pow",   bus.o_pow,      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue("p3_5",  3,  5, 32'h0000F300, 1'b0, 5, 1'b1);
        issue("m2_3", -2,  3, 32'hFFFFF800, 1'b0, 4, 1'b0);
        issue("m2_4", -2,  4, 32'h00001000, 1'b0, 5, 1'b0);
`ifdef POW_NEG_EXP_EN
        issue("p2_m3",   2, -3, 32'h00000020, 1'b0, 37, 1'b0);
        issue("p3_m9",   3, -9, 32'h00000000, 1'b0, 39, 1'b0);
        issue("m2_m3",  -2, -3, 32'hFFFFFFE0, 1'b0, 37, 1'b0);
        issue("m1_m1",  -1, -1, 32'hFFFFFF00, 1'b0, 36, 1'b0);
`else
        issue("p2_m3",   2, -3, 32'hDEADBEEF, 1'b1, 2, 1'b0);
        issue("p3_m9",   3, -9, 32'hDEADBEEF, 1'b1, 2, 1'b0);
        issue("m2_m3",  -2, -3, 32'hDEADBEEF, 1'b1, 2, 1'b0);
        issue("m1_m1",  -1, -1, 32'hDEADBEEF, 1'b1, 2, 1'b0);
`endif
        issue("p2_22",    2, 22, 32'h40000000, 1'b0, 7, 1'b0);
        issue("p2_23",    2, 23, 32'hDEADBEEF, 1'b1, 7, 1'b0);
        issue("p256_7", 256,  7, 32'hDEADBEEF, 1'b1, 4, 1'b0);
        issue("p300_4", 300,  4, 32'hDEADBEEF, 1'b1, 5, 1'b0);
        issue("z0_0",     0,  0, 32'h00000100, 1'b0, 2, 1'b0);
        issue("z0_m1",    0, -1, 32'hDEADBEEF, 1'b1, 2, 1'b0);
        issue("p5_0",     5,  0, 32'h00000100, 1'b0, 2, 1'b0);

        // Abort a request mid-loop; it must leave no done behind.
        bus.a     = 16'(3);
        bus.b     = 16'(15);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("abort_busy_before", 32'(bus.busy), 32'd1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy",  32'(bus.busy),  32'd0);
        chk("abort_done",  32'(bus.done),  32'd0);
        chk("abort_error", 32'(bus.error), 32'd0);
        chk("abort_pow",   bus.o_pow,      32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_idle_busy", 32'(bus.busy), 32'd0);

        issue("m3_3", -3, 3, 32'hFFFFE500, 1'b0, 4, 1'b0);
        repeat (5) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
